// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle pipeline results and queued long-latency
// results onto the register file's single write port, and tracks pending writes.
module writeback_arbiter #(
   parameter  int N_REGS     = 32,
   parameter  int R_WIDTH    = 32,
   parameter  int LQ_DEPTH   = 4,
   parameter  int STARVE_MAX = 3,
   localparam int W_ADDR     = $clog2(N_REGS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pipe_wb_valid,
   input  logic [W_ADDR-1:0]  pipe_wb_addr,
   input  logic [R_WIDTH-1:0] pipe_wb_data,
   input  logic               lat_valid,
   output logic               lat_ready,
   input  logic [W_ADDR-1:0]  lat_addr,
   input  logic [R_WIDTH-1:0] lat_data,
   input  logic               issue_valid,
   input  logic [W_ADDR-1:0]  issue_addr,
   output logic               rf_write,
   output logic [W_ADDR-1:0]  rf_addr,
   output logic [R_WIDTH-1:0] rf_data,
   output logic [N_REGS-1:0]  busy_vec,
   output logic               stall_req
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);
   localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_MAX);

   logic [W_ADDR-1:0]  q_addr [LQ_DEPTH];
   logic [R_WIDTH-1:0] q_data [LQ_DEPTH];

   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg, count_next;
   logic [AW-1:0]     head_age_reg;
   logic [N_REGS-1:0] busy_reg, busy_next;

   logic               pipe_win, q_empty, deq, accept, enq;
   logic [W_ADDR-1:0]  head_addr;
   logic [R_WIDTH-1:0] head_data;

   assign head_addr = q_addr[rd_ptr_reg];
   assign head_data = q_data[rd_ptr_reg];

   // A pipe write to x0 is not a real write, so it must not block the queue.
   assign pipe_win  = pipe_wb_valid && (pipe_wb_addr != '0);
   assign q_empty   = (count_reg == '0);
   assign deq       = !pipe_win && !q_empty;
   assign lat_ready = (count_reg != FULL_CNT);
   assign accept    = lat_valid && lat_ready;
   assign enq       = accept && (lat_addr != '0);

   assign rf_write  = rst_n && (pipe_win || !q_empty);
   assign rf_addr   = pipe_win ? pipe_wb_addr : head_addr;
   assign rf_data   = pipe_win ? pipe_wb_data : head_data;
   assign busy_vec  = busy_reg;
   assign stall_req = (head_age_reg >= AGE_MAX);

   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Set is applied after clear so a same-cycle reissue keeps the bit pending.
   always_comb begin
      busy_next = busy_reg;
      if (deq)
         busy_next[head_addr] = 1'b0;
      if (issue_valid && (issue_addr != '0))
         busy_next[issue_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_addr[wr_ptr_reg] <= lat_addr;
         q_data[wr_ptr_reg] <= lat_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         head_age_reg <= '0;
         busy_reg     <= '0;
      end else begin
         if (enq)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (deq)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
         busy_reg  <= busy_next;
         if (deq)
            head_age_reg <= '0;
         else if (!q_empty && (head_age_reg < AGE_MAX))
            head_age_reg <= head_age_reg + AW'(1);
      end
   end

`ifndef SYNTHESIS
   // Upstream must hold off pipeline results while a stall is requested.
   a_no_pipe_during_stall: assert property (
      @(posedge clk) disable iff (!rst_n) !(stall_req && pipe_wb_valid))
      else $error("pipe_wb_valid asserted while stall_req is high");
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: drives on the falling edge, checks 1 time unit later.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_wb_valid;
   logic [4:0]  pipe_wb_addr;
   logic [31:0] pipe_wb_data;
   logic        lat_valid;
   logic        lat_ready;
   logic [4:0]  lat_addr;
   logic [31:0] lat_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        rf_write;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] busy_vec;
   logic        stall_req;

   int checks   = 0;
   int failures = 0;

   writeback_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_wb_valid(pipe_wb_valid), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
      .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_addr(lat_addr), .lat_data(lat_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
      .busy_vec(busy_vec), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pipe_wb_valid = 0; pipe_wb_addr = 0; pipe_wb_data = 0;
      lat_valid = 0; lat_addr = 0; lat_data = 0;
      issue_valid = 0; issue_addr = 0;
   endtask

   task automatic pipe(input logic [4:0] a, input logic [31:0] d);
      pipe_wb_valid = 1; pipe_wb_addr = a; pipe_wb_data = d;
   endtask

   task automatic lat(input logic [4:0] a, input logic [31:0] d);
      lat_valid = 1; lat_addr = a; lat_data = d;
   endtask

   task automatic issue(input logic [4:0] a);
      issue_valid = 1; issue_addr = a;
   endtask

   task automatic step();
      @(negedge clk);
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      repeat (3) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst_lat_ready", 32'(lat_ready), 1);
      chk("rst_stall", 32'(stall_req), 0);
      chk("rst_busy", busy_vec, 0);
      chk("rst_rf_write", 32'(rf_write), 0);
      $display("txn reset released");

      // 1: pipeline write goes straight through
      step(); pipe(5, 32'hDEADBEEF); #1;
      chk("t1_wr", 32'(rf_write), 1);
      chk("t1_addr", 32'(rf_addr), 5);
      chk("t1_data", rf_data, 32'hDEADBEEF);
      chk("t1_busy", busy_vec, 0);
      $display("txn pipe x5 = deadbeef");

      // 2: issue x7, result one cycle later, written the cycle after acceptance
      step(); issue(7); #1;
      step(); lat(7, 32'h1234); #1;
      chk("t2_busy_set", busy_vec, 32'h80);
      chk("t2_ready", 32'(lat_ready), 1);
      chk("t2_no_wr_yet", 32'(rf_write), 0);
      step(); #1;
      chk("t2_wr", 32'(rf_write), 1);
      chk("t2_addr", 32'(rf_addr), 7);
      chk("t2_data", rf_data, 32'h1234);
      chk("t2_busy_held", busy_vec, 32'h80);
      step(); #1;
      chk("t2_idle", 32'(rf_write), 0);
      chk("t2_busy_clr", busy_vec, 0);
      $display("txn lat x7 = 1234");

      // 3: fill behind pipe writes, stall, then drain in order
      step(); pipe(3, 32'h33); lat(10, 32'hA0); #1;
      chk("t3_ready0", 32'(lat_ready), 1);
      chk("t3_pipe_wins", 32'(rf_addr), 3);
      step(); pipe(3, 32'h33); lat(11, 32'hA1); #1;
      chk("t3_pipe_data", rf_data, 32'h33);
      step(); pipe(3, 32'h33); lat(12, 32'hA2); #1;
      chk("t3_stall_lo", 32'(stall_req), 0);
      step(); pipe(3, 32'h33); lat(13, 32'hA3); #1;
      chk("t3_ready3", 32'(lat_ready), 1);
      chk("t3_stall_lo2", 32'(stall_req), 0);
      step(); lat(14, 32'hA4); #1;
      chk("t3_full", 32'(lat_ready), 0);
      chk("t3_stall_hi", 32'(stall_req), 1);
      chk("t3_d0_addr", 32'(rf_addr), 10);
      chk("t3_d0_data", rf_data, 32'hA0);
      step(); #1;
      chk("t3_ready_back", 32'(lat_ready), 1);
      chk("t3_stall_clr", 32'(stall_req), 0);
      chk("t3_d1_addr", 32'(rf_addr), 11);
      chk("t3_d1_data", rf_data, 32'hA1);
      step(); #1;
      chk("t3_d2_wr", 32'(rf_write), 1);
      chk("t3_d2_data", rf_data, 32'hA2);
      step(); #1;
      chk("t3_d3_wr", 32'(rf_write), 1);
      chk("t3_d3_addr", 32'(rf_addr), 13);
      chk("t3_d3_data", rf_data, 32'hA3);
      step(); #1;
      chk("t3_empty", 32'(rf_write), 0);
      $display("txn fill/drain x10..x13, x14 refused");

      // 4: x0 results from both sources
      step(); lat(20, 32'h2020); #1;
      step(); lat(0, 32'hBAD); pipe(0, 32'hBAD0); #1;
      chk("t4_x0_ready", 32'(lat_ready), 1);
      chk("t4_wr", 32'(rf_write), 1);
      chk("t4_addr", 32'(rf_addr), 20);
      chk("t4_data", rf_data, 32'h2020);
      step(); #1;
      chk("t4_x0_dropped", 32'(rf_write), 0);
      $display("txn x0 discarded, x20 = 2020");

      // 5: reissue of x9 on the cycle its queued result drains
      step(); issue(9); #1;
      step(); lat(9, 32'h99); #1;
      step(); issue(9); #1;
      chk("t5_addr", 32'(rf_addr), 9);
      chk("t5_data", rf_data, 32'h99);
      step(); #1;
      chk("t5_busy_kept", busy_vec, 32'h200);
      chk("t5_idle", 32'(rf_write), 0);
      $display("txn x9 set-wins");

      // 6: reset with three queued entries and pending bits
      step(); issue(1); lat(1, 32'h11); pipe(4, 32'h44); #1;
      step(); issue(2); lat(2, 32'h22); pipe(4, 32'h44); #1;
      step(); issue(3); lat(3, 32'h33); pipe(4, 32'h44); #1;
      step(); #1;
      chk("t6_busy_pre", busy_vec, 32'h20E);
      chk("t6_head_pre", 32'(rf_addr), 1);
      rst_n = 0; pipe(4, 32'h44); #1;
      chk("t6_rst_no_wr", 32'(rf_write), 0);
      chk("t6_rst_busy", busy_vec, 0);
      @(negedge clk); idle(); rst_n = 1; #1;
      chk("t6_ready", 32'(lat_ready), 1);
      chk("t6_stall", 32'(stall_req), 0);
      chk("t6_no_stale", 32'(rf_write), 0);
      chk("t6_busy", busy_vec, 0);
      step(); #1;
      chk("t6_no_stale2", 32'(rf_write), 0);
      $display("txn reset mid-operation");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
